// File: rtl/rr_arb_num_vc_pkg.sv
// Shared definitions for the VC allocators.
// Provides the lock FSM state encoding and the width helpers that
// are used to size VC index fields.
package rr_arb_num_vc_pkg;

    // FSM encodings. Other VC allocators reuse these values.
    localparam logic FSM_IDLE_ENC   = 1'b0;
    localparam logic FSM_LOCKED_ENC = 1'b1;

    typedef enum logic {
        VC_IDLE   = FSM_IDLE_ENC,
        VC_LOCKED = FSM_LOCKED_ENC
    } vc_fsm_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a VC index. It is never narrower than one bit, so a
    // single-VC network still has a legal index field.
    function automatic int vc_index_bits(input int n);
        return max_int(1, log2_ceil(n));
    endfunction

endpackage

// File: rtl/rr_arb_vn_slice.sv
// Round-robin arbiter with packet lock for a single virtual network.
//
// State table
//   state     | meaning
//   VC_IDLE   | grant = first request at or after ptr (wrapping)
//   VC_LOCKED | grant pinned to lvc until its tail flit is accepted
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   req          request per VC
//   ack          consumer accepts the current grant this cycle
//   tail         accepted flit is a packet tail (qualified by ack)
//   grant        one-hot grant
//   grant_valid  grant is valid
//   grant_vc     binary index of the granted VC
module rr_arb_vn_slice
    import rr_arb_num_vc_pkg::*;
#(
    parameter int NUM_VC  = 4,
    parameter int BITS_VC = vc_index_bits(NUM_VC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_VC-1:0]  req,
    input  logic               ack,
    input  logic               tail,
    output logic [NUM_VC-1:0]  grant,
    output logic               grant_valid,
    output logic [BITS_VC-1:0] grant_vc
);

    vc_fsm_e            state;
    logic [BITS_VC-1:0] ptr;
    logic [BITS_VC-1:0] lvc;
    logic [BITS_VC-1:0] scan_idx;
    logic               scan_found;
    logic [BITS_VC-1:0] gnt_idx;
    logic               gnt_any;

    // Wrap by compare rather than overflow, so non-power-of-two VC
    // counts return to zero after NUM_VC-1.
    function automatic logic [BITS_VC-1:0] wrap_inc(input logic [BITS_VC-1:0] x);
        if (int'(x) == NUM_VC - 1) begin
            return '0;
        end
        return x + BITS_VC'(1);
    endfunction

    // Rotate-then-priority-encode, expressed as a scan starting at ptr.
    always_comb begin
        int k;
        k          = 0;
        scan_found = 1'b0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_VC) begin
                k = k - NUM_VC;
            end
            if (!scan_found && req[k[BITS_VC-1:0]]) begin
                scan_found = 1'b1;
                scan_idx   = k[BITS_VC-1:0];
            end
        end
    end

    always_comb begin
        gnt_idx     = (state == VC_LOCKED) ? lvc : scan_idx;
        gnt_any     = (state == VC_LOCKED) || scan_found;
        grant_valid = (state == VC_LOCKED) ? req[lvc] : scan_found;
        grant_vc    = gnt_idx;
        grant       = '0;
        for (int j = 0; j < NUM_VC; j++) begin
            grant[j] = gnt_any && (int'(gnt_idx) == j);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= VC_IDLE;
            ptr   <= '0;
            lvc   <= '0;
        end else if (grant_valid && ack) begin
            if (state == VC_IDLE) begin
                if (tail) begin
                    ptr <= wrap_inc(gnt_idx);
                end else begin
                    state <= VC_LOCKED;
                    lvc   <= gnt_idx;
                end
            end else if (tail) begin
                state <= VC_IDLE;
                ptr   <= wrap_inc(lvc);
            end
        end
    end

endmodule

// File: rtl/rr_arb_num_vc.sv
// Per-virtual-network round-robin VC arbiter with packet locking.
// Each VN is arbitrated by its own rr_arb_vn_slice; grants are
// combinational from the requests and the registered slice state.
//
// Ports
//   clk              clock
//   rst_n            synchronous active-low reset
//   req_in           requests, VN v at [v*NUM_VC +: NUM_VC]
//   ack_in           per-VN accept of the current grant
//   tail_in          per-VN tail flag of the accepted flit
//   grant_out        one-hot grants, same packing as req_in
//   grant_valid_out  per-VN grant valid
//   grant_vc_out     granted VC index, VN v at [v*bits_vc +: bits_vc]
module rr_arb_num_vc
    import rr_arb_num_vc_pkg::*;
#(
    parameter int NUM_VC = 4,
    parameter int NUM_VN = 3
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_VN*NUM_VC-1:0]                 req_in,
    input  logic [NUM_VN-1:0]                        ack_in,
    input  logic [NUM_VN-1:0]                        tail_in,
    output logic [NUM_VN*NUM_VC-1:0]                 grant_out,
    output logic [NUM_VN-1:0]                        grant_valid_out,
    output logic [NUM_VN*vc_index_bits(NUM_VC)-1:0]  grant_vc_out
);

    localparam int bits_vc = vc_index_bits(NUM_VC);

    for (genvar v = 0; v < NUM_VN; v++) begin : g_vn
        rr_arb_vn_slice #(
            .NUM_VC  (NUM_VC),
            .BITS_VC (bits_vc)
        ) u_slice (
            .clk         (clk),
            .rst_n       (rst_n),
            .req         (req_in[v*NUM_VC +: NUM_VC]),
            .ack         (ack_in[v]),
            .tail        (tail_in[v]),
            .grant       (grant_out[v*NUM_VC +: NUM_VC]),
            .grant_valid (grant_valid_out[v]),
            .grant_vc    (grant_vc_out[v*bits_vc +: bits_vc])
        );
    end

endmodule

// File: tb/tb_rr_arb_num_vc.sv
// Bench for rr_arb_num_vc. Four configurations run side by side:
//   d0: NUM_VC=4 NUM_VN=3   d1: NUM_VC=3 NUM_VN=1
//   d2: NUM_VC=5 NUM_VN=1   d3: NUM_VC=1 NUM_VN=2
// A behavioural model (modular scan, integer pointers) predicts every
// output each cycle; directed phases add fixed expected values.
module tb_rr_arb_num_vc;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [11:0] req0;  logic [2:0] ack0, tail0;
    logic [11:0] g0;    logic [2:0] gv0;  logic [5:0] gvc0;
    logic [2:0]  req1;  logic ack1, tail1;
    logic [2:0]  g1;    logic gv1;        logic [1:0] gvc1;
    logic [4:0]  req2;  logic ack2, tail2;
    logic [4:0]  g2;    logic gv2;        logic [2:0] gvc2;
    logic [1:0]  req3;  logic [1:0] ack3, tail3;
    logic [1:0]  g3;    logic [1:0] gv3;  logic [1:0] gvc3;

    rr_arb_num_vc #(.NUM_VC(4), .NUM_VN(3)) u_d0 (
        .clk(clk), .rst_n(rst_n), .req_in(req0), .ack_in(ack0), .tail_in(tail0),
        .grant_out(g0), .grant_valid_out(gv0), .grant_vc_out(gvc0));
    rr_arb_num_vc #(.NUM_VC(3), .NUM_VN(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .req_in(req1), .ack_in(ack1), .tail_in(tail1),
        .grant_out(g1), .grant_valid_out(gv1), .grant_vc_out(gvc1));
    rr_arb_num_vc #(.NUM_VC(5), .NUM_VN(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .req_in(req2), .ack_in(ack2), .tail_in(tail2),
        .grant_out(g2), .grant_valid_out(gv2), .grant_vc_out(gvc2));
    rr_arb_num_vc #(.NUM_VC(1), .NUM_VN(2)) u_d3 (
        .clk(clk), .rst_n(rst_n), .req_in(req3), .ack_in(ack3), .tail_in(tail3),
        .grant_out(g3), .grant_valid_out(gv3), .grant_vc_out(gvc3));

    int nvc [4] = '{4, 3, 5, 1};
    int nvn [4] = '{3, 1, 1, 2};

    logic [7:0] rq [4][4];
    bit         ak [4][4];
    bit         tl [4][4];

    int  m_ptr  [4][4];
    bit  m_lock [4][4];
    int  m_lvc  [4][4];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_grant(input int d, input int v);
        case (d)
            0:       return 8'(g0[v*4 +: 4]);
            1:       return 8'(g1);
            2:       return 8'(g2);
            default: return 8'(g3[v]);
        endcase
    endfunction

    function automatic logic dut_valid(input int d, input int v);
        case (d)
            0:       return gv0[v];
            1:       return gv1;
            2:       return gv2;
            default: return gv3[v];
        endcase
    endfunction

    function automatic int dut_vc(input int d, input int v);
        case (d)
            0:       return int'(gvc0[v*2 +: 2]);
            1:       return int'(gvc1);
            2:       return int'(gvc2);
            default: return int'(gvc3[v]);
        endcase
    endfunction

    // Expected outputs straight from the arbitration rules.
    task automatic model_out(input int d, input int v, output logic [7:0] eg,
                             output logic ev, output int evc);
        int n, idx;
        n = nvc[d];
        eg = '0; ev = 1'b0; evc = 0;
        if (m_lock[d][v]) begin
            evc = m_lvc[d][v];
            eg  = 8'(1 << evc);
            ev  = rq[d][v][evc];
        end else begin
            for (int k = 0; k < n; k++) begin
                idx = (m_ptr[d][v] + k) % n;
                if (!ev && rq[d][v][idx]) begin
                    ev  = 1'b1;
                    evc = idx;
                    eg  = 8'(1 << idx);
                end
            end
        end
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 4; d++)
            for (int v = 0; v < 4; v++) begin
                rq[d][v] = '0; ak[d][v] = 1'b0; tl[d][v] = 1'b0;
            end
    endtask

    // Drive the ports from the stimulus arrays and compare against the model.
    task automatic settle();
        logic [7:0] eg; logic ev; int evc;
        for (int v = 0; v < 3; v++) begin
            req0[v*4 +: 4] = rq[0][v][3:0]; ack0[v] = ak[0][v]; tail0[v] = tl[0][v];
        end
        req1 = rq[1][0][2:0]; ack1 = ak[1][0]; tail1 = tl[1][0];
        req2 = rq[2][0][4:0]; ack2 = ak[2][0]; tail2 = tl[2][0];
        for (int v = 0; v < 2; v++) begin
            req3[v] = rq[3][v][0]; ack3[v] = ak[3][v]; tail3[v] = tl[3][v];
        end
        #1;
        for (int d = 0; d < 4; d++)
            for (int v = 0; v < nvn[d]; v++) begin
                model_out(d, v, eg, ev, evc);
                chk($sformatf("d%0d_vn%0d_grant", d, v), 32'(dut_grant(d, v)), 32'(eg));
                chk($sformatf("d%0d_vn%0d_valid", d, v), 32'(dut_valid(d, v)), 32'(ev));
                chk($sformatf("d%0d_vn%0d_vc", d, v), 32'(dut_vc(d, v)), 32'(evc));
            end
    endtask

    // Apply the clock edge to the model, then to the DUT.
    task automatic advance();
        logic [7:0] eg; logic ev; int evc;
        for (int d = 0; d < 4; d++)
            for (int v = 0; v < nvn[d]; v++) begin
                model_out(d, v, eg, ev, evc);
                if (!rst_n) begin
                    m_lock[d][v] = 1'b0; m_ptr[d][v] = 0; m_lvc[d][v] = 0;
                end else if (ev && ak[d][v]) begin
                    if (!m_lock[d][v]) begin
                        if (tl[d][v]) m_ptr[d][v] = (evc + 1) % nvc[d];
                        else begin m_lock[d][v] = 1'b1; m_lvc[d][v] = evc; end
                    end else if (tl[d][v]) begin
                        m_lock[d][v] = 1'b0;
                        m_ptr[d][v]  = (m_lvc[d][v] + 1) % nvc[d];
                    end
                end
            end
        @(posedge clk);
        #1;
    endtask

    int fair_seq [6] = '{0, 1, 2, 3, 4, 0};

    initial begin
        for (int d = 0; d < 4; d++)
            for (int v = 0; v < 4; v++) begin
                m_ptr[d][v] = 0; m_lock[d][v] = 1'b0; m_lvc[d][v] = 0;
            end
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk); #1;

        // reset with idle inputs
        settle();
        chk("reset_grant0", 32'(g0), 32'h0);
        chk("reset_valid0", 32'(gv0), 32'h0);
        advance();
        settle(); advance();
        rst_n = 1'b1;

        // basic rotation on d0 VN0
        rq[0][0] = 8'b1010; ak[0][0] = 1'b1; tl[0][0] = 1'b1;
        settle();
        chk("rot_first_grant", 32'(g0[3:0]), 32'b0010);
        chk("rot_first_vc", 32'(gvc0[1:0]), 32'd1);
        advance();
        ak[0][0] = 1'b0; tl[0][0] = 1'b0;
        settle();
        chk("rot_second_grant", 32'(g0[3:0]), 32'b1000);
        chk("rot_second_vc", 32'(gvc0[1:0]), 32'd3);
        advance();
        clear_inputs();

        // wrap on NUM_VC=3
        rq[1][0] = 8'b010; ak[1][0] = 1'b1; tl[1][0] = 1'b1;
        settle(); advance();
        ak[1][0] = 1'b0; tl[1][0] = 1'b0; rq[1][0] = 8'b011;
        settle();
        chk("wrap_ptr2_grant", 32'(g1), 32'b001);
        advance();
        rq[1][0] = 8'b100; ak[1][0] = 1'b1; tl[1][0] = 1'b1;
        settle();
        chk("wrap_top_grant", 32'(g1), 32'b100);
        advance();
        rq[1][0] = 8'b011; ak[1][0] = 1'b0; tl[1][0] = 1'b0;
        settle();
        chk("wrap_ptr0_grant", 32'(g1), 32'b001);
        advance();
        clear_inputs();

        // lock on d0 VN1
        rq[0][1] = 8'b0101; ak[0][1] = 1'b1; tl[0][1] = 1'b0;
        settle();
        chk("lock_take_vc", 32'(gvc0[3:2]), 32'd0);
        advance();
        rq[0][1] = 8'b0111; ak[0][1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("lock_hold_vc", 32'(gvc0[3:2]), 32'd0);
            chk("lock_hold_grant", 32'(g0[7:4]), 32'b0001);
            advance();
        end
        ak[0][1] = 1'b1; tl[0][1] = 1'b1;
        settle(); advance();
        rq[0][1] = 8'b0101; ak[0][1] = 1'b0; tl[0][1] = 1'b0;
        settle();
        chk("lock_release_next_vc", 32'(gvc0[3:2]), 32'd2);
        advance();
        clear_inputs();

        // fairness on NUM_VC=5 (ptr still 0 since reset)
        rq[2][0] = 8'b11111; ak[2][0] = 1'b1; tl[2][0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            settle();
            chk($sformatf("fair_vc_%0d", c), 32'(gvc2), 32'(fair_seq[c]));
            advance();
        end
        clear_inputs();

        // independence on d0: VN1 pointer moved to 2 first
        rq[0][1] = 8'b0010; ak[0][1] = 1'b1; tl[0][1] = 1'b1;
        settle(); advance();
        clear_inputs();
        rq[0][0] = 8'b0001; ak[0][0] = 1'b1; tl[0][0] = 1'b1;
        rq[0][2] = 8'b0100; ak[0][2] = 1'b1; tl[0][2] = 1'b1;
        rq[0][1] = 8'b0110;
        settle();
        chk("indep_vn1_vc", 32'(gvc0[3:2]), 32'd2);
        advance();
        clear_inputs();
        ak[0][1] = 1'b1; tl[0][1] = 1'b1;
        settle();
        chk("ack_noreq_valid", 32'(gv0[1]), 32'd0);
        advance();
        clear_inputs();
        rq[0][1] = 8'b0110;
        settle();
        chk("indep_vn1_vc_after", 32'(gvc0[3:2]), 32'd2);
        advance();
        clear_inputs();

        // reset in the middle of a packet locked on vc3
        rq[0][0] = 8'b1000; ak[0][0] = 1'b1; tl[0][0] = 1'b0;
        settle(); advance();
        rst_n = 1'b0; tl[0][0] = 1'b1;
        settle(); advance();
        rst_n = 1'b1; clear_inputs();
        rq[0][0] = 8'b1111;
        settle();
        chk("rst_mid_lowest_vc", 32'(gvc0[1:0]), 32'd0);
        advance();
        rq[0][0] = 8'b0110;
        settle();
        chk("rst_mid_unlocked_vc", 32'(gvc0[1:0]), 32'd1);
        advance();
        clear_inputs();

        // single-VC network: lock persists through a request drop
        rq[3][0] = 8'b1; ak[3][0] = 1'b1;
        settle(); advance();
        clear_inputs();
        settle();
        chk("vc1_locked_valid", 32'(gv3[0]), 32'd0);
        chk("vc1_locked_grant", 32'(g3[0]), 32'd1);
        advance();

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            for (int d = 0; d < 4; d++)
                for (int v = 0; v < 4; v++) begin
                    rq[d][v] = 8'($urandom) & 8'((1 << nvc[d]) - 1);
                    ak[d][v] = ($urandom_range(0, 2) != 0);
                    tl[d][v] = ($urandom_range(0, 1) != 0);
                end
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
